// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the approximate restoring divider.
package div_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

    // Width of a counter that must hold values up to n.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the remainder,
// then subtract the divisor if it fits.
module div_step #(
    parameter int WIDTH = 12
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] t;
    logic [WIDTH:0] diff;

    always_comb begin
        t        = {rem, bit_in};
        diff     = t - {1'b0, divisor};
        q_bit    = (t >= {1'b0, divisor});
        // rem < divisor on entry, so the difference always fits in WIDTH bits.
        rem_next = q_bit ? diff[WIDTH-1:0] : t[WIDTH-1:0];
    end

endmodule

// File: rtl/approx_divider.sv
// Multi-cycle approximate restoring divider: 2W/W -> W, low APPROX_BITS of the
// quotient skipped. Optional round-to-nearest step enabled by `DIV_ROUND_EN.
module approx_divider
    import div_pkg::*;
#(
    parameter int WIDTH       = 12,
    parameter int APPROX_BITS = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   quotient,
    output logic               ovf,
    output logic               dbz
);

    localparam int N = WIDTH - APPROX_BITS;
`ifdef DIV_ROUND_EN
    localparam int STEPS = N + 1;
`else
    localparam int STEPS = N;
`endif
    localparam int CW = cnt_w(STEPS);

    div_state_t       state;
    logic [WIDTH-1:0] rem, sreg, dvs;
    logic [STEPS-1:0] qbits, qb_nx;
    logic [CW-1:0]    cnt;
    logic             chk;
    logic [WIDTH-1:0] rem_nx;
    logic             q_bit;
    logic [WIDTH-1:0] res;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .bit_in   (sreg[WIDTH-1]),
        .divisor  (dvs),
        .rem_next (rem_nx),
        .q_bit    (q_bit)
    );

    always_comb begin
        qb_nx = (qbits << 1) | STEPS'(q_bit);
`ifdef DIV_ROUND_EN
        begin
            logic [WIDTH:0] sum;
            sum = {1'b0, WIDTH'(qb_nx >> 1) << APPROX_BITS};
            if (qb_nx[0])
                sum = sum + ((WIDTH+1)'(1) << APPROX_BITS);
            res = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
        end
`else
        res = WIDTH'(qb_nx) << APPROX_BITS;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quotient  <= '0;
            ovf       <= 1'b0;
            dbz       <= 1'b0;
            rem       <= '0;
            sreg      <= '0;
            dvs       <= '0;
            qbits     <= '0;
            cnt       <= '0;
            chk       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        rem      <= dividend[2*WIDTH-1:WIDTH];
                        sreg     <= dividend[WIDTH-1:0];
                        dvs      <= divisor;
                        qbits    <= '0;
                        cnt      <= '0;
                        chk      <= 1'b1;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    if (chk) begin
                        // First CALC cycle only screens for dbz/ovf on the latched operands.
                        chk <= 1'b0;
                        if (dvs == '0 || rem >= dvs) begin
                            dbz       <= (dvs == '0);
                            ovf       <= (dvs != '0);
                            quotient  <= '1;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end else begin
                        rem   <= rem_nx;
                        sreg  <= sreg << 1;
                        qbits <= qb_nx;
                        cnt   <= cnt + 1'b1;
                        if (cnt == CW'(STEPS - 1)) begin
                            quotient  <= res;
                            ovf       <= 1'b0;
                            dbz       <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
